// File: rtl/operand_fetch_pkg.sv
// Operand fetch shared types: widths, FSM states,
// the latched instruction bundle and a bypass-match helper.
package operand_fetch_pkg;

  localparam int REGS_DATA_W = 32;
  localparam int REGS_ADDR_W = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    OF_IDLE = 2'd0,
    OF_OPER = 2'd1,
    OF_HOLD = 2'd2
  } of_state_e;

  typedef struct packed {
    logic [REGS_ADDR_W-1:0] rs;
    logic [REGS_ADDR_W-1:0] rt;
    logic                   use_rs;
    logic                   use_rt;
    logic [REGS_DATA_W-1:0] imm;
    logic [REGS_ADDR_W-1:0] rd;
    logic                   wen;
  } of_instr_t;

  // Producer writes src, and src is not the hardwired zero register.
  function automatic logic src_hit(
    input logic                   wen,
    input logic [REGS_ADDR_W-1:0] waddr,
    input logic [REGS_ADDR_W-1:0] src
  );
    return wen && (waddr == src) && (src != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and EX-side valid/ready bundles
// around the operand fetch block.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = REGS_DATA_W,
  parameter int ADDR_WIDTH = REGS_ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rs;
  logic [ADDR_WIDTH-1:0] in_rt;
  logic                  in_use_rs;
  logic                  in_use_rt;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_wen;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_op_a;
  logic [DATA_WIDTH-1:0] out_op_b;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_wen;

  modport master (
    output in_valid,
    output in_rs,
    output in_rt,
    output in_use_rs,
    output in_use_rt,
    output in_imm,
    output in_rd,
    output in_wen,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_op_a,
    input  out_op_b,
    input  out_rd,
    input  out_wen
  );

  modport slave (
    input  in_valid,
    input  in_rs,
    input  in_rt,
    input  in_use_rs,
    input  in_use_rt,
    input  in_imm,
    input  in_rd,
    input  in_wen,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_op_a,
    output out_op_b,
    output out_rd,
    output out_wen
  );

endinterface

// File: rtl/operand_forward.sv
// One-source operand resolver: EX result beats MEM
// result beats register file data; index 0 never bypassed.
module operand_forward
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = REGS_DATA_W,
  parameter int ADDR_WIDTH = REGS_ADDR_W
) (
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0] gpr_data,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] value
);

  logic ex_hit;
  logic mem_hit;
  logic mem_only;

  // A load in EX has no data yet, so it cannot bypass.
  assign ex_hit = src_hit(ex_wen & ~ex_is_load,
                          ex_waddr, src);
  assign mem_hit  = src_hit(mem_wen, mem_waddr, src);
  assign mem_only = mem_hit & ~ex_hit;

  // Select the youngest available copy of the source.
  always_comb begin
    value = gpr_data;
    unique case (1'b1)
      ex_hit:   value = ex_wdata;
      mem_only: value = mem_wdata;
      default:  value = gpr_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// ID-side operand collector: drives gpr_file reads,
// applies EX/MEM bypass, stalls on load-use, hands to EX.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = REGS_DATA_W,
  parameter int ADDR_WIDTH = REGS_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  operand_fetch_if.slave        bus,
  output logic                  gpr_re1,
  output logic                  gpr_re2,
  output logic [ADDR_WIDTH-1:0] gpr_ra1,
  output logic [ADDR_WIDTH-1:0] gpr_ra2,
  input  logic [DATA_WIDTH-1:0] gpr_rd1,
  input  logic [DATA_WIDTH-1:0] gpr_rd2,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  of_state_e state_q;
  of_state_e state_d;

  of_instr_t instr_q;
  of_instr_t in_instr;
  of_instr_t sel;

  logic in_ready;
  logic accept;
  logic hazard;
  logic capture;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] op_a_d;
  logic [DATA_WIDTH-1:0] op_b_d;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_op_a_q;
  logic [DATA_WIDTH-1:0] out_op_b_q;
  logic [ADDR_WIDTH-1:0] out_rd_q;
  logic                  out_wen_q;

  assign in_instr = '{
    rs:     bus.in_rs,
    rt:     bus.in_rt,
    use_rs: bus.in_use_rs,
    use_rt: bus.in_use_rt,
    imm:    bus.in_imm,
    rd:     bus.in_rd,
    wen:    bus.in_wen
  };

  // Acceptance window; closed during reset and redirect.
  always_comb begin
    in_ready = DISABLE;
    if (!reset && !flush) begin
      unique case (state_q)
        OF_IDLE: in_ready = ENABLE;
        OF_OPER: in_ready = DISABLE;
        OF_HOLD: in_ready = bus.out_ready;
        default: in_ready = DISABLE;
      endcase
    end
  end

  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  // New fields go straight to the read ports on accept,
  // so data lands while the instruction sits in OPER.
  assign sel     = accept ? in_instr : instr_q;
  assign gpr_ra1 = sel.rs;
  assign gpr_ra2 = sel.rt;
  assign gpr_re1 = sel.use_rs & ~reset;
  assign gpr_re2 = sel.use_rt & ~reset;

  // Load in EX feeding a used source: wait for MEM.
  assign hazard =
    (instr_q.use_rs &
     src_hit(ex_wen & ex_is_load, ex_waddr, instr_q.rs)) |
    (instr_q.use_rt &
     src_hit(ex_wen & ex_is_load, ex_waddr, instr_q.rt));

  operand_forward #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_rs (
    .src        (instr_q.rs),
    .gpr_data   (gpr_rd1),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .value      (fwd_a)
  );

  operand_forward #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd_rt (
    .src        (instr_q.rt),
    .gpr_data   (gpr_rd2),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .value      (fwd_b)
  );

  assign op_a_d = instr_q.use_rs ? fwd_a : '0;
  assign op_b_d = instr_q.use_rt ? fwd_b : instr_q.imm;

  assign capture = (state_q == OF_OPER) & ~hazard & ~flush;

  // Next-state: redirect wins, then per-state progress.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OF_IDLE;
    end else begin
      unique case (state_q)
        OF_IDLE: begin
          if (accept) state_d = OF_OPER;
        end
        OF_OPER: begin
          if (!hazard) state_d = OF_HOLD;
        end
        OF_HOLD: begin
          if (bus.out_ready) begin
            state_d = accept ? OF_OPER : OF_IDLE;
          end
        end
        default: state_d = OF_IDLE;
      endcase
    end
  end

  // State and latched instruction fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OF_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= in_instr;
    end
  end

  // Output valid: set on resolve, cleared on take or redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
    end else if (state_q == OF_HOLD && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Output payload: loaded once per instruction, then held.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_op_a_q <= '0;
      out_op_b_q <= '0;
      out_rd_q   <= '0;
      out_wen_q  <= 1'b0;
    end else if (capture) begin
      out_op_a_q <= op_a_d;
      out_op_b_q <= op_b_d;
      out_rd_q   <= instr_q.rd;
      out_wen_q  <= instr_q.wen;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op_a  = out_op_a_q;
  assign bus.out_op_b  = out_op_b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wen   = out_wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a gpr_file model
// and an expected-result queue.
module tb_operand_fetch;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        gpr_re1;
  logic        gpr_re2;
  logic [4:0]  gpr_ra1;
  logic [4:0]  gpr_ra2;
  logic [31:0] gpr_rd1;
  logic [31:0] gpr_rd2;
  logic        ex_wen;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .bus        (ifc.slave),
    .gpr_re1    (gpr_re1),
    .gpr_re2    (gpr_re2),
    .gpr_ra1    (gpr_ra1),
    .gpr_ra2    (gpr_ra2),
    .gpr_rd1    (gpr_rd1),
    .gpr_rd2    (gpr_rd2),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] regs [32];
  int          checks;
  int          errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: one-cycle registered read.
  always @(posedge clock) begin
    if (gpr_re1) gpr_rd1 <= (gpr_ra1 == 5'd0) ? 32'd0 : regs[gpr_ra1];
    if (gpr_re2) gpr_rd2 <= (gpr_ra2 == 5'd0) ? 32'd0 : regs[gpr_ra2];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic [4:0] rs,
                          input logic [4:0] rt,
                          input logic urs,
                          input logic urt,
                          input logic [31:0] imm,
                          input logic [4:0] rd,
                          input logic wen,
                          input logic [31:0] ea,
                          input logic [31:0] eb,
                          input bit push,
                          input string tag);
    ifc.in_valid  = 1'b1;
    ifc.in_rs     = rs;
    ifc.in_rt     = rt;
    ifc.in_use_rs = urs;
    ifc.in_use_rt = urt;
    ifc.in_imm    = imm;
    ifc.in_rd     = rd;
    ifc.in_wen    = wen;
    #1;
    chk({tag, "_rdy"}, 32'(ifc.in_ready), 32'd1);
    chk({tag, "_ra1"}, 32'(gpr_ra1), 32'(rs));
    chk({tag, "_re1"}, 32'(gpr_re1), 32'(urs));
    chk({tag, "_re2"}, 32'(gpr_re2), 32'(urt));
    if (push) sb.push_back('{a: ea, b: eb, rd: rd, wen: wen});
  endtask

  task automatic wait_out(input int exp_lat, input string tag);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clock);
      if (i == 1) ifc.in_valid = 1'b0;
      n = i;
      if (ifc.out_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_op_a"}, ifc.out_op_a, e.a);
        chk({tag, "_op_b"}, ifc.out_op_b, e.b);
        chk({tag, "_rd"}, 32'(ifc.out_rd), 32'(e.rd));
        chk({tag, "_wen"}, 32'(ifc.out_wen), 32'(e.wen));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[3] = 32'd33;
    gpr_rd1 = '0;
    gpr_rd2 = '0;
    reset = 1'b1;
    flush = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_rs     = '0;
    ifc.in_rt     = '0;
    ifc.in_use_rs = 1'b1;
    ifc.in_use_rt = 1'b1;
    ifc.in_imm    = '0;
    ifc.in_rd     = '0;
    ifc.in_wen    = 1'b0;
    ifc.out_ready = 1'b1;
    ex_wen = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_wen = 0; mem_waddr = 0; mem_wdata = 0;

    // reset state
    ifc.in_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_re1", 32'(gpr_re1), 32'd0);
    chk("rst_re2", 32'(gpr_re2), 32'd0);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_op_a", ifc.out_op_a, 32'd0);
    ifc.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // 1: plain register reads
    drive_in(1, 2, 1, 1, 0, 3, 1, 5, 7, 1, "t1");
    wait_out(2, "t1");

    // 2: back-to-back, EX beats MEM on rs
    ex_wen = 1; ex_waddr = 1; ex_wdata = 99;
    mem_wen = 1; mem_waddr = 1; mem_wdata = 3;
    drive_in(1, 2, 1, 1, 0, 4, 1, 99, 7, 1, "t2");
    wait_out(2, "t2");

    // 2b: MEM forwards on rt, EX targets unused reg
    ex_waddr = 3; mem_waddr = 2; mem_wdata = 11;
    drive_in(1, 2, 1, 1, 0, 4, 0, 5, 11, 1, "t2b");
    wait_out(2, "t2b");
    ex_wen = 0; mem_wen = 0;
    @(negedge clock);

    // 3: load-use on rt, one stall cycle
    ex_wen = 1; ex_is_load = 1; ex_waddr = 2; ex_wdata = 123;
    drive_in(1, 2, 1, 1, 0, 6, 1, 5, 42, 1, "t3");
    @(negedge clock);
    ifc.in_valid = 1'b0;
    chk("t3_stall1", 32'(ifc.out_valid), 32'd0);
    chk("t3_ra2", 32'(gpr_ra2), 32'd2);
    @(negedge clock);
    chk("t3_stall2", 32'(ifc.out_valid), 32'd0);
    ex_wen = 0; ex_is_load = 0;
    mem_wen = 1; mem_waddr = 2; mem_wdata = 42;
    wait_out(1, "t3");
    mem_wen = 0;
    @(negedge clock);

    // 3b: load on an unused rs does not stall
    ex_wen = 1; ex_is_load = 1; ex_waddr = 1;
    drive_in(1, 2, 0, 1, 0, 6, 1, 0, 7, 1, "t3b");
    wait_out(2, "t3b");
    ex_wen = 0; ex_is_load = 0;
    @(negedge clock);

    // 4: index 0 never forwarded; immediate on B
    ex_wen = 1; ex_waddr = 0; ex_wdata = 55;
    drive_in(0, 5, 1, 0, 32'hFFFF_FFF0, 7, 0,
             0, 32'hFFFF_FFF0, 1, "t4");
    wait_out(2, "t4");
    ex_wen = 0;
    @(negedge clock);

    // 5: backpressure, then accept on the take cycle
    ifc.out_ready = 1'b0;
    drive_in(3, 1, 1, 1, 0, 8, 1, 33, 5, 1, "t5");
    wait_out(2, "t5");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t5_hold_v", 32'(ifc.out_valid), 32'd1);
      chk("t5_hold_a", ifc.out_op_a, 32'd33);
      chk("t5_hold_b", ifc.out_op_b, 32'd5);
      chk("t5_hold_rdy", 32'(ifc.in_ready), 32'd0);
    end
    ifc.out_ready = 1'b1;
    drive_in(2, 3, 1, 1, 0, 9, 0, 7, 33, 1, "t5n");
    wait_out(2, "t5n");
    @(negedge clock);

    // 6: flush in OPER
    drive_in(1, 2, 1, 1, 0, 10, 1, 0, 0, 0, "t6");
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("t6_fl_valid", 32'(ifc.out_valid), 32'd0);
    #1;
    chk("t6_fl_idle", 32'(ifc.in_ready), 32'd1);
    repeat (2) @(negedge clock);
    chk("t6_fl_quiet", 32'(ifc.out_valid), 32'd0);

    // 6b: flush in HOLD blocks a same-cycle accept
    drive_in(3, 3, 1, 1, 0, 11, 1, 33, 33, 1, "t6b");
    wait_out(2, "t6b");
    flush = 1'b1;
    ifc.in_valid = 1'b1;
    #1;
    chk("t6b_fl_rdy", 32'(ifc.in_ready), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("t6b_fl_valid", 32'(ifc.out_valid), 32'd0);
    repeat (3) @(negedge clock);
    chk("t6b_no_accept", 32'(ifc.out_valid), 32'd0);

    // 6c: reset in HOLD clears everything
    ifc.out_ready = 1'b0;
    drive_in(2, 1, 1, 1, 0, 12, 1, 7, 5, 1, "t6r");
    wait_out(2, "t6r");
    reset = 1'b1;
    #1;
    chk("t6r_rdy", 32'(ifc.in_ready), 32'd0);
    chk("t6r_re1", 32'(gpr_re1), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("t6r_valid", 32'(ifc.out_valid), 32'd0);
    chk("t6r_op_a", ifc.out_op_a, 32'd0);
    chk("t6r_op_b", ifc.out_op_b, 32'd0);
    chk("t6r_rd", 32'(ifc.out_rd), 32'd0);
    chk("t6r_wen", 32'(ifc.out_wen), 32'd0);
    #1;
    chk("t6r_idle", 32'(ifc.in_ready), 32'd1);
    ifc.out_ready = 1'b1;
    @(negedge clock);

    // recovery after reset
    drive_in(1, 3, 1, 1, 0, 13, 1, 5, 33, 1, "t7");
    wait_out(2, "t7");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
